// File: rtl/lab2_pkg.sv
// Shared types and constants for the lab2 truth-table scanner.
package lab2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } scan_state_t;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/lab2_settle_cnt.sv
// Loadable down-counter that times how long a vector is held before sampling.
module lab2_settle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] cnt_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = cnt_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lab2_scanner.sv
// Walks every input vector through an attached combinational block, captures its
// truth table and checks it against a golden mask latched when the scan is accepted.
module lab2_scanner
  import lab2_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic                 pass,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail
);

  localparam int                  TT_W       = 2**N_IN;
  localparam logic [N_IN-1:0]     LAST_VEC   = {N_IN{1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);

  scan_state_t       state_q;
  logic [N_IN-1:0]   vec_q;
  logic              busy_q;
  logic              done_q;
  logic [TT_W-1:0]   tt_q;
  logic [TT_W-1:0]   expected_q;
  logic              pass_q;
  logic              fail_valid_q;
  logic [N_IN-1:0]   first_fail_q;

  logic              last_vec;
  logic              mismatch;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  always_comb begin
    last_vec = (vec_q == LAST_VEC);
    mismatch = (dut_out != expected_q[vec_q]);
    // Reload the settle time whenever a vector is about to enter DRIVE.
    cnt_load = ((state_q == IDLE) && start) || ((state_q == SAMPLE) && !last_vec);
    cnt_dec  = (state_q == DRIVE) && !cnt_zero;
  end

  lab2_settle_cnt #(
    .W (SETTLE_W)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .cnt_val (SETTLE_VAL),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tt_q         <= '0;
      expected_q   <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            expected_q   <= expected;
            tt_q         <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            vec_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_zero) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          tt_q[vec_q] <= dut_out;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            first_fail_q <= vec_q;
          end
          if (last_vec) begin
            // pass must already include this final sample when done is seen.
            pass_q  <= !(fail_valid_q || mismatch);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= DRIVE;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tt         = tt_q;
  assign pass       = pass_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_lab2_scanner.sv
// Directed bench for lab2_scanner: three instances (SETTLE 1, 0, 15) with a
// behavioural gate model on dut_out and a scoreboard of predicted scan results.
module tb_lab2_scanner;

  localparam int N_IN = 4;
  localparam int TT_W = 16;
  localparam int NI   = 3;
  localparam int ST [NI] = '{1, 0, 15};

  logic clk;
  logic rst;

  logic              start_v   [NI];
  logic [TT_W-1:0]   exp_in    [NI];
  logic              dout_v    [NI];
  logic [N_IN-1:0]   vec_a     [NI];
  logic              busy_v    [NI];
  logic              done_v    [NI];
  logic [TT_W-1:0]   tt_a      [NI];
  logic              pass_v    [NI];
  logic              fv_v      [NI];
  logic [N_IN-1:0]   ff_a      [NI];
  int                mode_a    [NI];

  // {pass, fail_valid, first_fail, tt}
  logic [21:0] exp_q [$];

  int n_cmp;
  int n_err;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic lab2_1(input logic [3:0] v);
    logic a, b, c, d;
    a = v[0]; b = v[1]; c = v[2]; d = v[3];
    return ~(~(a & b) & ~(c | d));
  endfunction

  function automatic logic model(input int m, input logic [3:0] v);
    case (m)
      0:       return v[0];
      1:       return v[3];
      2:       return lab2_1(v);
      3:       return lab2_1(v) ^ (v == 4'd9);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [TT_W-1:0] table_of(input int m);
    logic [TT_W-1:0] t;
    t = '0;
    for (int i = 0; i < TT_W; i++) t[i] = model(m, 4'(i));
    return t;
  endfunction

  function automatic logic [21:0] predict(input int m, input logic [TT_W-1:0] mask);
    logic [TT_W-1:0] t;
    logic [TT_W-1:0] x;
    logic [3:0]      ff;
    logic            fv;
    t  = table_of(m);
    x  = t ^ mask;
    fv = |x;
    ff = '0;
    for (int i = TT_W - 1; i >= 0; i--) if (x[i]) ff = 4'(i);
    return {~fv, fv, ff, t};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign dout_v[g] = model(mode_a[g], vec_a[g]);
    lab2_scanner #(
      .N_IN   (N_IN),
      .SETTLE (ST[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_v[g]),
      .expected   (exp_in[g]),
      .dut_out    (dout_v[g]),
      .vec        (vec_a[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .tt         (tt_a[g]),
      .pass       (pass_v[g]),
      .fail_valid (fv_v[g]),
      .first_fail (ff_a[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done on instance k; also measures how long each vector stays put.
  task automatic wait_done(input int k, input int cyc0, input int disturb,
                           output int cyc, output int min_run, output int max_run,
                           output int nvec);
    int run;
    logic [3:0] last_v;
    cyc = cyc0; min_run = 1000; max_run = 0; nvec = 0;
    run = busy_v[k] ? 1 : 0;
    last_v = vec_a[k];
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (disturb != 0 && cyc == 10) start_v[k] = 1'b1;
      if (disturb != 0 && cyc == 11) start_v[k] = 1'b0;
      if (disturb != 0 && cyc == 15) exp_in[k] = ~exp_in[k];
      if (done_v[k]) break;
      if (busy_v[k]) begin
        if (run > 0 && vec_a[k] != last_v) begin
          if (run < min_run) min_run = run;
          if (run > max_run) max_run = run;
          run = 0;
          nvec++;
        end
        last_v = vec_a[k];
        run++;
      end
    end
    if (run > 0) begin
      if (run < min_run) min_run = run;
      if (run > max_run) max_run = run;
      nvec++;
    end
  endtask

  task automatic check_result(input int k, input string tag);
    logic [21:0] r;
    if (exp_q.size() == 0) begin
      chk({tag, ".sb_nonempty"}, 0, 1);
    end else begin
      r = exp_q.pop_front();
      chk({tag, ".tt"},         tt_a[k],  r[15:0]);
      chk({tag, ".first_fail"}, ff_a[k],  r[19:16]);
      chk({tag, ".fail_valid"}, fv_v[k],  r[20]);
      chk({tag, ".pass"},       pass_v[k], r[21]);
    end
  endtask

  task automatic check_timing(input int k, input string tag, input int cyc,
                              input int mn, input int mx, input int nv);
    chk({tag, ".latency"},   cyc, 16 * (ST[k] + 2) + 1);
    chk({tag, ".busy_done"}, busy_v[k], 0);
    chk({tag, ".min_hold"},  mn, ST[k] + 2);
    chk({tag, ".max_hold"},  mx, ST[k] + 2);
    chk({tag, ".nvec"},      nv, 16);
  endtask

  // Driver: one complete scan on instance k, entered and left on a negedge in IDLE.
  task automatic scan(input int k, input int m, input logic [TT_W-1:0] mask,
                      input int disturb, input string tag);
    int cyc, mn, mx, nv;
    exp_q.push_back(predict(m, mask));
    mode_a[k]  = m;
    exp_in[k]  = mask;
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    chk({tag, ".busy1"}, busy_v[k], 1);
    chk({tag, ".vec1"},  vec_a[k], 0);
    wait_done(k, 1, disturb, cyc, mn, mx, nv);
    check_timing(k, tag, cyc, mn, mx, nv);
    check_result(k, tag);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input int k, input string tag);
    chk({tag, ".vec"},        vec_a[k], 0);
    chk({tag, ".busy"},       busy_v[k], 0);
    chk({tag, ".done"},       done_v[k], 0);
    chk({tag, ".tt"},         tt_a[k], 0);
    chk({tag, ".pass"},       pass_v[k], 0);
    chk({tag, ".fail_valid"}, fv_v[k], 0);
    chk({tag, ".first_fail"}, ff_a[k], 0);
  endtask

  initial begin
    int cyc, mn, mx, nv, seen;
    logic [TT_W-1:0] l21;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      exp_in[i]  = '0;
      mode_a[i]  = 0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals(0, "por0");
    check_reset_vals(2, "por2");
    rst = 1'b0;
    @(negedge clk);

    l21 = table_of(2);
    scan(0, 0, 16'hAAAA, 0, "vec0");
    scan(0, 1, 16'hFF01, 0, "vec3");
    scan(0, 2, l21, 0, "lab2_1");
    scan(0, 3, l21, 0, "lab2_1_bad9");
    scan(1, 0, 16'hAAAA, 0, "settle0");
    scan(2, 2, l21, 0, "settle15");
    scan(0, 1, 16'hFF01, 1, "disturb");

    // Reset in the middle of a scan.
    mode_a[0]  = 0;
    exp_in[0]  = 16'hAAAA;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals(0, "midrst");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    chk("midrst.no_done", seen, 0);
    scan(0, 2, l21, 0, "after_rst");

    // start held high: back-to-back scans with one IDLE cycle in between.
    exp_q.push_back(predict(0, 16'hAAAA));
    exp_q.push_back(predict(0, 16'hAAAA));
    mode_a[0]  = 0;
    exp_in[0]  = 16'hAAAA;
    start_v[0] = 1'b1;
    @(negedge clk);
    chk("held.busy1", busy_v[0], 1);
    wait_done(0, 1, 0, cyc, mn, mx, nv);
    check_timing(0, "held_a", cyc, mn, mx, nv);
    check_result(0, "held_a");
    @(negedge clk);
    chk("held.idle_busy", busy_v[0], 0);
    chk("held.idle_done", done_v[0], 0);
    @(negedge clk);
    chk("held.rearm_busy", busy_v[0], 1);
    chk("held.rearm_vec",  vec_a[0], 0);
    start_v[0] = 1'b0;
    wait_done(0, 1, 0, cyc, mn, mx, nv);
    check_timing(0, "held_b", cyc, mn, mx, nv);
    check_result(0, "held_b");
    @(negedge clk);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lab2_scanner.md
# lab2_scanner

Sequential truth-table scanner that sits directly upstream of the lab2 combinational gate networks (the 4-input NAND/NOR network and the 3-input majority-style functions). On a start request it drives every input combination into the attached combinational block. It waits a programmable settle time, samples the block's output, and assembles a full truth-table word. It then compares that word against an expected mask and reports pass/fail and the first failing vector.

## Interface
Parameters:
- `N_IN`, 4: number of combinational inputs driven; truth table width is `2**N_IN`.
- `SETTLE`, 1: wait cycles between driving a vector and sampling the output; range 0–15.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: scan request; accepted only in IDLE.
- `expected`  in  `2**N_IN`: golden truth table; bit i is the required output for vector i; latched at start.
- `dut_out`  in  1: output of the combinational block under scan.
- `vec`  out  `N_IN`: input vector driven to the combinational block; bit 0 maps to `in1`/`x`.
- `busy`  out  1: high from the cycle after accept through the final sample.
- `done`  out  1: one-cycle pulse when the result is valid.
- `tt`  out  `2**N_IN`: captured truth table; bit i is the `dut_out` sample for `vec`=i.
- `pass`  out  1: `tt == expected`; valid from `done` until the next accept.
- `fail_valid`  out  1: at least one mismatch found.
- `first_fail`  out  `N_IN`: lowest vector index with a mismatch; 0 when `fail_valid`=0.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - `start`=1 → latch `expected`, clear `tt`/`fail_valid`/`first_fail`/`pass`, set `vec`=0, go to DRIVE.
  - Otherwise stay; `vec` holds its last value.
- DRIVE:
  - The settle counter counts 0..`SETTLE`-1, then goes to SAMPLE.
  - With `SETTLE`=0, DRIVE lasts exactly one cycle before SAMPLE; DRIVE is never skipped.
- SAMPLE:
  - `tt[vec]` ← `dut_out`.
  - If `dut_out` ≠ `expected_q[vec]` and `fail_valid`=0: set `fail_valid`=1 and `first_fail`←`vec`.
  - If `vec` = `2**N_IN`-1, go to FINISH. Otherwise `vec`←`vec`+1, go to DRIVE.
- FINISH: `done`=1 for this single cycle, `pass`←(`fail_valid`=0), return to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- `vec` never wraps during a scan; the increment from the last vector is suppressed.
- Reset at any time (mid-scan included): immediate return to IDLE. Partial results are discarded, with no `done` pulse.
- `expected` changes after accept have no effect on the running scan.

## Timing
- Reset values: `vec`=0, `busy`=0, `done`=0, `tt`=0, `pass`=0, `fail_valid`=0, `first_fail`=0, FSM=IDLE, settle counter=0.
- Accept at cycle 0 (`start` high in IDLE):
  - Cycle 1: `busy`=1 and `vec`=0.
  - Each vector occupies `SETTLE`+1 cycles in DRIVE plus 1 cycle in SAMPLE, i.e. `SETTLE`+2 cycles.
  - The last SAMPLE ends at cycle `2**N_IN`·(`SETTLE`+2).
  - `done` is high in the following cycle, with `busy`=0 in that same cycle.
- Start-to-done latency is `2**N_IN`·(`SETTLE`+2)+1 cycles; for the defaults that is 16·3+1 = 49.
- `dut_out` is sampled in SAMPLE only. `vec` is stable for at least `SETTLE`+1 full cycles before the sample edge.
- `start` held high continuously starts a new scan in the cycle after FINISH, i.e. the first IDLE cycle.
- `tt`, `pass`, `fail_valid` and `first_fail` hold their values from `done` until the next accept.

## Structure
- Shared package `lab2_pkg`:
  - `scan_state_t` enum (IDLE, DRIVE, SAMPLE, FINISH).
  - Localparam `SETTLE_W`=4 for the settle counter width.
- Sub-module `lab2_settle_cnt`: parameterised down-counter with `load`, `cnt_val` and a `zero` flag. It is instantiated once for the DRIVE timing.
- The top module holds the FSM, the `vec` counter, the `tt` shift/index capture and the mismatch tracker.

## Test plan
- `dut_out`=`vec[0]`, `expected`=16'hAAAA, `SETTLE`=1:
  - `done` at start+49, `tt`=16'hAAAA, `pass`=1, `fail_valid`=0.
- `dut_out`=`vec[3]`, `expected`=16'hFF01:
  - `tt`=16'hFF00, `pass`=0, `fail_valid`=1, `first_fail`=0.
- `dut_out` driven by a behavioural model of the lab2_1 network, `expected` from the same model:
  - `pass`=1.
  - Repeat with one model output bit inverted at vector 9: `first_fail`=9.
- `SETTLE`=0 and `SETTLE`=15:
  - `done` at start+33 and start+273 respectively.
  - `vec` is stable for `SETTLE`+1 cycles before each sample.
- Assert `rst` at cycle 20 of a scan:
  - All outputs return to their reset values the same cycle; no `done` pulse.
  - A new `start` then gives a full, correct scan.
- Pulse `start` during `busy`, and change `expected` mid-scan:
  - Both are ignored; the result matches the latched `expected`.
  - With `start` held high, back-to-back scans run with exactly one IDLE cycle between `done` and the next `busy`.
